adsr_envelope: RTL and testbench
================================

Name: adsr_envelope

Overview:
- Amplitude envelope stage directly downstream of the phase oscillator.
- Consumes the oscillator's 32-bit wavetable sample and scales it by an ADSR envelope level (attack, decay, sustain, release).
- Driven by note-on and note-off events from the key/voice controller. Its output feeds the voice mixer.
- Runs on the master clock. All level and sample updates are qualified by a one-cycle sample-rate tick.

Parameters:
- SAMPLE_W, 32, width of the input and output audio sample (two's complement)
- LEVEL_W, 16, width of the unsigned envelope level; full scale is all ones
- RATE_W, 16, width of the attack, decay and release rate inputs

Ports:
- MasterCLK  in  1  system clock; the only clock
- Reset  in  1  asynchronous, active-high reset
- SampleTick  in  1  one-cycle pulse at the sampling rate (FSCLK rising edge, synchronised upstream)
- NoteOn  in  1  one-cycle pulse; start or retrigger the envelope
- NoteOff  in  1  one-cycle pulse; begin release
- AttackRate  in  RATE_W  level increment per tick in ATTACK
- DecayRate  in  RATE_W  level decrement per tick in DECAY
- SustainLevel  in  8  sustain target; expanded to {S,S} (0xFF maps to 0xFFFF)
- ReleaseRate  in  RATE_W  level decrement per tick in RELEASE
- WTIn  in  SAMPLE_W  oscillator sample, signed
- EnvOut  out  SAMPLE_W  enveloped sample, signed
- EnvLevel  out  LEVEL_W  current envelope level
- EnvState  out  3  current state encoding (see package)
- Active  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (asynchronous): state=IDLE, EnvLevel=0, EnvOut=0, Active=0.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Note events take effect on the clock edge where they are asserted, whether or not SampleTick is high. Level arithmetic happens only on SampleTick cycles.
- NoteOn from any state: go to ATTACK. The level is kept, not cleared, to avoid clicks on retrigger.
- NoteOff in ATTACK, DECAY or SUSTAIN: go to RELEASE. NoteOff in IDLE or RELEASE is ignored.
- NoteOn and NoteOff in the same cycle: NoteOn wins.
- A note event on a SampleTick cycle: the new state applies, and that tick's level update uses the new state's rule.
- ATTACK, per tick:
  - level += AttackRate, saturating at 0xFFFF.
  - On reaching 0xFFFF: go to DECAY.
  - AttackRate=0 means an instant jump to 0xFFFF.
- DECAY, per tick:
  - level -= DecayRate.
  - If the result is <= the sustain target or underflows: clamp to the target and go to SUSTAIN.
  - DecayRate=0 means an instant clamp.
  - If the level is already <= the target on entry: clamp and go to SUSTAIN on the next tick.
- SUSTAIN: level follows the sustain target on each tick, so live SustainLevel changes track.
- RELEASE, per tick:
  - level -= ReleaseRate, with floor 0.
  - On reaching 0: go to IDLE.
  - ReleaseRate=0 means an instant drop to 0.
- IDLE: level holds 0.
- Output, on each SampleTick:
  - EnvOut <= (signed WTIn × zero-extended pre-update level) >>> LEVEL_W.
  - This is an arithmetic shift, i.e. truncation toward negative infinity.
  - Intermediate product width is SAMPLE_W+LEVEL_W+1. No saturation is needed because the level is < 1.0.
  - Latency: EnvOut is valid one MasterCLK cycle after the tick and holds until the next tick.
- EnvLevel and EnvState are registered. Active is decoded from the state register.
- SampleTick held high for more than one cycle: each high cycle counts as a tick. The upstream stage guarantees single-cycle pulses.

Decomposition:
- Package synth_pkg:
  - env_state_t enum: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
  - LEVEL_MAX constant.
  - Sustain-expansion function.
- Sub-module env_scaler: the registered signed×unsigned multiply and shift, enabled by SampleTick. Reused by the mixer's master volume.

Test Plan:
- Attack ramp:
  - Stimulus: Reset, then NoteOn with AttackRate=0x1000 and ticks.
  - Required: EnvLevel=0xF000 after 15 ticks; 0xFFFF after tick 16; EnvState=DECAY.
- Decay to sustain:
  - Stimulus: continue with DecayRate=0x0100, SustainLevel=0x80.
  - Required: level 0x80FF after 127 decay ticks; clamps to 0x8080 at tick 128; state SUSTAIN.
- Release to idle:
  - Stimulus: NoteOff with ReleaseRate=0x0800.
  - Required: level 0x0080 after 16 ticks; 0 at tick 17; IDLE; Active=0.
- Scaling:
  - Stimulus: level 0x8000 with WTIn=0x4000_0000.
  - Required: EnvOut=0x2000_0000 one cycle after the tick.
  - Stimulus: WTIn=0xC000_0000.
  - Required: EnvOut=0xE000_0000.
- Retrigger and collision:
  - Stimulus: NoteOn during RELEASE at level 0x4000.
  - Required: ATTACK starts from 0x4000.
  - Stimulus: NoteOn and NoteOff in the same cycle.
  - Required: state ATTACK.
- Reset mid-operation:
  - Stimulus: assert Reset mid-ATTACK, between clock edges.
  - Required: immediately IDLE with EnvLevel=0 and EnvOut=0; ticks have no effect while Reset is held.

Source files
------------

// File: rtl/synth_pkg.sv
// synth_pkg: shared envelope state encoding, level limits and sustain expansion
package synth_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;
  localparam logic [15:0] LEVEL_MAX = 16'hFFFF;
  function automatic logic [15:0] sustain_expand(input logic [7:0] s);
    return {s, s};
  endfunction
endpackage

// File: rtl/env_scaler.sv
// env_scaler: registered signed sample times unsigned gain, floored back to sample width
module env_scaler #(
  parameter int SAMPLE_W = 32,
  parameter int LEVEL_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] din,
  input  logic        [LEVEL_W-1:0]  gain,
  output logic signed [SAMPLE_W-1:0] dout
);
  logic signed [SAMPLE_W+LEVEL_W:0] prod;
  assign prod = din * $signed({1'b0, gain});
  always_ff @(posedge clk or posedge rst)
    if (rst) dout <= '0;
    else if (en) dout <= SAMPLE_W'(prod >>> LEVEL_W);
endmodule

// File: rtl/adsr_envelope.sv
// adsr_envelope: ADSR level generator scaling the oscillator sample once per sample tick
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int SAMPLE_W = 32,
  parameter int LEVEL_W  = 16,
  parameter int RATE_W   = 16
) (
  input  logic                MasterCLK,
  input  logic                Reset,
  input  logic                SampleTick,
  input  logic                NoteOn,
  input  logic                NoteOff,
  input  logic [RATE_W-1:0]   AttackRate,
  input  logic [RATE_W-1:0]   DecayRate,
  input  logic [7:0]          SustainLevel,
  input  logic [RATE_W-1:0]   ReleaseRate,
  input  logic [SAMPLE_W-1:0] WTIn,
  output logic [SAMPLE_W-1:0] EnvOut,
  output logic [LEVEL_W-1:0]  EnvLevel,
  output logic [2:0]          EnvState,
  output logic                Active
);
  env_state_t st, st_ev, st_nx;
  logic [LEVEL_W-1:0] tgt, lvl_nx, lmax;
  logic [LEVEL_W:0] add, dec, rel;
  assign lmax = LEVEL_W'(LEVEL_MAX);
  assign EnvState = st;
  assign Active = st != IDLE;
  // note events resolve first so a same-cycle tick uses the new state's rule
  always_comb begin
    tgt = LEVEL_W'(sustain_expand(SustainLevel));
    st_ev = NoteOn ? ATTACK : (NoteOff && st != IDLE && st != RELEASE) ? RELEASE : st;
    add = {1'b0, EnvLevel} + (LEVEL_W+1)'(AttackRate);
    dec = {1'b0, EnvLevel} - (LEVEL_W+1)'(DecayRate);
    rel = {1'b0, EnvLevel} - (LEVEL_W+1)'(ReleaseRate);
    st_nx = st_ev;
    lvl_nx = EnvLevel;
    if (SampleTick)
      case (st_ev)
        ATTACK: begin
          st_nx = (AttackRate == '0 || add[LEVEL_W] || add[LEVEL_W-1:0] == lmax) ? DECAY : ATTACK;
          lvl_nx = (st_nx == DECAY) ? lmax : add[LEVEL_W-1:0];
        end
        DECAY: begin
          st_nx = (DecayRate == '0 || dec[LEVEL_W] || dec[LEVEL_W-1:0] <= tgt) ? SUSTAIN : DECAY;
          lvl_nx = (st_nx == SUSTAIN) ? tgt : dec[LEVEL_W-1:0];
        end
        SUSTAIN: lvl_nx = tgt;
        RELEASE: begin
          st_nx = (ReleaseRate == '0 || rel[LEVEL_W] || rel[LEVEL_W-1:0] == '0) ? IDLE : RELEASE;
          lvl_nx = (st_nx == IDLE) ? '0 : rel[LEVEL_W-1:0];
        end
        default: lvl_nx = '0;
      endcase
  end
  always_ff @(posedge MasterCLK or posedge Reset)
    if (Reset) begin
      st <= IDLE;
      EnvLevel <= '0;
    end else begin
      st <= st_nx;
      EnvLevel <= lvl_nx;
    end
  env_scaler #(.SAMPLE_W(SAMPLE_W), .LEVEL_W(LEVEL_W)) u_scaler (
    .clk (MasterCLK),
    .rst (Reset),
    .en  (SampleTick),
    .din (WTIn),
    .gain(EnvLevel),
    .dout(EnvOut)
  );
endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: directed ADSR walk-through with hand-computed levels and scaled samples
module tb_adsr_envelope;
  logic clk = 1'b0;
  logic rst, tick, non, noff;
  logic [15:0] ar, dr, rr;
  logic [7:0] sl;
  logic [31:0] wt, env_out;
  logic [15:0] env_level;
  logic [2:0] env_state;
  logic active;
  int passed = 0, fails = 0, total = 0;
  localparam logic [2:0] S_IDLE = 3'd0, S_ATK = 3'd1, S_DEC = 3'd2, S_SUS = 3'd3, S_REL = 3'd4;

  adsr_envelope dut (
    .MasterCLK(clk), .Reset(rst), .SampleTick(tick), .NoteOn(non), .NoteOff(noff),
    .AttackRate(ar), .DecayRate(dr), .SustainLevel(sl), .ReleaseRate(rr),
    .WTIn(wt), .EnvOut(env_out), .EnvLevel(env_level), .EnvState(env_state), .Active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic t, input logic on, input logic off);
    @(negedge clk);
    tick = t; non = on; noff = off;
    @(posedge clk);
    #1;
    tick = 1'b0; non = 1'b0; noff = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; non = 1'b0; noff = 1'b0;
    ar = 16'h1000; dr = 16'h0100; sl = 8'h80; rr = 16'h0800; wt = '0;
    #12;
    chk("rst_level", env_level, 16'h0000);
    chk("rst_state", env_state, S_IDLE);
    chk("rst_active", active, 1'b0);
    chk("rst_out", env_out, 32'h0);
    @(negedge clk) rst = 1'b0;

    step(1'b0, 1'b1, 1'b0);
    chk("on_state", env_state, S_ATK);
    chk("on_level", env_level, 16'h0000);
    chk("on_active", active, 1'b1);
    ticks(15);
    chk("atk15_level", env_level, 16'hF000);
    chk("atk15_state", env_state, S_ATK);
    ticks(1);
    chk("atk16_level", env_level, 16'hFFFF);
    chk("atk16_state", env_state, S_DEC);

    ticks(127);
    chk("dec127_level", env_level, 16'h80FF);
    chk("dec127_state", env_state, S_DEC);
    ticks(1);
    chk("dec128_level", env_level, 16'h8080);
    chk("dec128_state", env_state, S_SUS);
    sl = 8'h40;
    ticks(1);
    chk("sus_track_lo", env_level, 16'h4040);
    sl = 8'h80;
    ticks(1);
    chk("sus_track_hi", env_level, 16'h8080);

    step(1'b0, 1'b0, 1'b1);
    chk("off_state", env_state, S_REL);
    chk("off_level", env_level, 16'h8080);
    ticks(16);
    chk("rel16_level", env_level, 16'h0080);
    ticks(1);
    chk("rel17_level", env_level, 16'h0000);
    chk("rel17_state", env_state, S_IDLE);
    chk("rel17_active", active, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("off_idle_ignored", env_state, S_IDLE);

    ar = 16'h8000;
    wt = 32'h4000_0000;
    step(1'b1, 1'b1, 1'b0);
    chk("on_tick_level", env_level, 16'h8000);
    chk("on_tick_out_prelevel", env_out, 32'h0);
    ticks(1);
    chk("scale_pos", env_out, 32'h2000_0000);
    chk("atk_sat_state", env_state, S_DEC);
    step(1'b0, 1'b0, 1'b0);
    chk("out_hold", env_out, 32'h2000_0000);

    rr = 16'h0000;
    step(1'b1, 1'b0, 1'b1);
    chk("rel0_level", env_level, 16'h0000);
    chk("rel0_state", env_state, S_IDLE);
    wt = 32'hC000_0000;
    step(1'b1, 1'b1, 1'b0);
    chk("on2_level", env_level, 16'h8000);
    ticks(1);
    chk("scale_neg", env_out, 32'hE000_0000);
    chk("atk2_level", env_level, 16'hFFFF);
    wt = 32'hFFFF_FFFF;
    ticks(1);
    chk("scale_floor", env_out, 32'hFFFF_FFFF);
    chk("dec_step_level", env_level, 16'hFEFF);

    rr = 16'hBEFF;
    step(1'b1, 1'b0, 1'b1);
    chk("rel_tick_state", env_state, S_REL);
    chk("rel_tick_level", env_level, 16'h4000);
    ar = 16'h1000;
    step(1'b0, 1'b1, 1'b0);
    chk("retrig_state", env_state, S_ATK);
    chk("retrig_level", env_level, 16'h4000);
    ticks(1);
    chk("retrig_step", env_level, 16'h5000);

    step(1'b0, 1'b0, 1'b1);
    chk("off_atk_state", env_state, S_REL);
    step(1'b0, 1'b1, 1'b1);
    chk("collide_state", env_state, S_ATK);
    chk("collide_level", env_level, 16'h5000);

    ar = 16'h0000;
    ticks(1);
    chk("atk0_level", env_level, 16'hFFFF);
    chk("atk0_state", env_state, S_DEC);
    dr = 16'h0000;
    ticks(1);
    chk("dec0_level", env_level, 16'h8080);
    chk("dec0_state", env_state, S_SUS);

    ar = 16'h0100;
    wt = 32'h4000_0000;
    step(1'b0, 1'b1, 1'b0);
    ticks(1);
    chk("mid_level", env_level, 16'h8180);
    chk("mid_out", env_out, 32'h2020_0000);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", env_state, S_IDLE);
    chk("arst_level", env_level, 16'h0000);
    chk("arst_out", env_out, 32'h0);
    chk("arst_active", active, 1'b0);
    @(negedge clk);
    tick = 1'b1; non = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("held_level", env_level, 16'h0000);
    chk("held_out", env_out, 32'h0);
    chk("held_state", env_state, S_IDLE);
    tick = 1'b0; non = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
